// File: rtl/control_pkg.sv
// Shared encodings for the accumulator-processor controller: FSM states,
// opcodes and A-register source selects.
package control_pkg;

  typedef enum logic [3:0] {
    ST_START  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_LOAD   = 4'd3,
    ST_STORE  = 4'd4,
    ST_ADD    = 4'd5,
    ST_SUB    = 4'd6,
    ST_INPUT  = 4'd7,
    ST_JZ     = 4'd8,
    ST_JPOS   = 4'd9,
    ST_HALT   = 4'd10
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_RAM = 2'b10;

endpackage

// File: rtl/control_unit_enter_sync.sv
// Enter-button synchronizer followed by a registered rising-edge detector;
// emits one clean 1-cycle pulse per press, STAGES+1 clocks after the edge.
module enter_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enter_i,
  output logic pulse_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              pulse_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], enter_i};
      prev_q  <= sync_q[STAGES-1];
      // Registered so the FSM sees a glitch-free pulse.
      pulse_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/control_unit.sv
// Moore FSM sequencing FETCH/DECODE/execute for the 8-bit accumulator
// processor; drives all datapath strobes and the IN-instruction handshake.
module control_unit
  import control_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] ir,
  input  logic       aEq0,
  input  logic       aPos,
  input  logic       enter,
  output logic       irLoad,
  output logic       pcLoad,
  output logic       jmpMux,
  output logic       memInst,
  output logic       memWr,
  output logic [1:0] aSel,
  output logic       aLoad,
  output logic       sub,
  output logic       halt,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   enter_pulse;

  enter_sync #(.STAGES(SYNC_STAGES)) u_enter_sync (
    .clock   (clock),
    .reset   (reset),
    .enter_i (enter),
    .pulse_o (enter_pulse)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_START;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_START;
    irLoad  = 1'b0;
    pcLoad  = 1'b0;
    jmpMux  = 1'b0;
    memInst = 1'b0;
    memWr   = 1'b0;
    aSel    = ASEL_ALU;
    aLoad   = 1'b0;
    sub     = 1'b0;
    halt    = 1'b0;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        irLoad  = 1'b1;
        pcLoad  = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        memInst = 1'b1;
        case (ir)
          OP_LOAD:  state_d = ST_LOAD;
          OP_STORE: state_d = ST_STORE;
          OP_ADD:   state_d = ST_ADD;
          OP_SUB:   state_d = ST_SUB;
          OP_INPUT: state_d = ST_INPUT;
          OP_JZ:    state_d = ST_JZ;
          OP_JPOS:  state_d = ST_JPOS;
          default:  state_d = ST_HALT;
        endcase
      end
      ST_LOAD: begin
        memInst = 1'b1;
        aSel    = ASEL_RAM;
        aLoad   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_STORE: begin
        memInst = 1'b1;
        memWr   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_ADD: begin
        memInst = 1'b1;
        aLoad   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_SUB: begin
        memInst = 1'b1;
        sub     = 1'b1;
        aLoad   = 1'b1;
        state_d = ST_FETCH;
      end
      // Pulses arriving outside INPUT are simply ignored, never queued.
      ST_INPUT: begin
        aSel    = ASEL_IN;
        aLoad   = enter_pulse;
        state_d = enter_pulse ? ST_FETCH : ST_INPUT;
      end
      ST_JZ: begin
        jmpMux  = 1'b1;
        pcLoad  = aEq0;
        state_d = ST_FETCH;
      end
      ST_JPOS: begin
        jmpMux  = 1'b1;
        pcLoad  = aPos;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halt    = 1'b1;
        state_d = ST_HALT;
      end
      default: state_d = ST_START;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench: stimulus pushes the expected per-cycle output vector into a
// scoreboard queue; a monitor pops and compares at each falling edge.
module tb_control_unit;

  localparam int SYNC = 2;

  // {state, irLoad pcLoad jmpMux memInst memWr, aSel, aLoad sub halt}
  localparam logic [13:0] V_START  = {4'd0,  5'b00000, 2'b00, 3'b000};
  localparam logic [13:0] V_FETCH  = {4'd1,  5'b11000, 2'b00, 3'b000};
  localparam logic [13:0] V_DECODE = {4'd2,  5'b00010, 2'b00, 3'b000};
  localparam logic [13:0] V_LOAD   = {4'd3,  5'b00010, 2'b10, 3'b100};
  localparam logic [13:0] V_STORE  = {4'd4,  5'b00011, 2'b00, 3'b000};
  localparam logic [13:0] V_ADD    = {4'd5,  5'b00010, 2'b00, 3'b100};
  localparam logic [13:0] V_SUB    = {4'd6,  5'b00010, 2'b00, 3'b110};
  localparam logic [13:0] V_INWAIT = {4'd7,  5'b00000, 2'b01, 3'b000};
  localparam logic [13:0] V_INGO   = {4'd7,  5'b00000, 2'b01, 3'b100};
  localparam logic [13:0] V_JZ_T   = {4'd8,  5'b01100, 2'b00, 3'b000};
  localparam logic [13:0] V_JZ_N   = {4'd8,  5'b00100, 2'b00, 3'b000};
  localparam logic [13:0] V_JP_T   = {4'd9,  5'b01100, 2'b00, 3'b000};
  localparam logic [13:0] V_JP_N   = {4'd9,  5'b00100, 2'b00, 3'b000};
  localparam logic [13:0] V_HALT   = {4'd10, 5'b00000, 2'b00, 3'b001};

  logic       clock, reset, aEq0, aPos, enter;
  logic [2:0] ir;
  logic       irLoad, pcLoad, jmpMux, memInst, memWr, aLoad, sub, halt;
  logic [1:0] aSel;
  logic [3:0] state;

  control_unit #(.SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(reset), .ir(ir), .aEq0(aEq0), .aPos(aPos),
    .enter(enter), .irLoad(irLoad), .pcLoad(pcLoad), .jmpMux(jmpMux),
    .memInst(memInst), .memWr(memWr), .aSel(aSel), .aLoad(aLoad),
    .sub(sub), .halt(halt), .state(state)
  );

  typedef struct {
    logic [13:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  event async_chk;

  wire [13:0] act = {state, irLoad, pcLoad, jmpMux, memInst, memWr, aSel, aLoad, sub, halt};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Monitor: compare whatever the stimulus expects for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or async_chk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got %h want %h at %0t", e.nm, act, e.v, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_v(input logic [13:0] v, input string nm);
    exp_t e;
    e.v  = v;
    e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic instr(input logic [2:0] op, input logic eq, input logic pos,
                       input logic [13:0] v, input string nm);
    tick(); ir = op; aEq0 = eq; aPos = pos; expect_v(V_FETCH, {nm, "_fetch"});
    tick(); expect_v(V_DECODE, {nm, "_decode"});
    tick(); expect_v(v, nm);
  endtask

  task automatic fetch_decode(input logic [2:0] op, input string nm);
    tick(); ir = op; expect_v(V_FETCH, {nm, "_fetch"});
    tick(); expect_v(V_DECODE, {nm, "_decode"});
  endtask

  // Async reset mid-cycle: outputs must clear before the next clock edge.
  task automatic async_reset(input string nm);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    expect_v(V_START, nm);
    ->async_chk;
    tick(); expect_v(V_START, {nm, "_held"});
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; ir = 3'b000; aEq0 = 1'b0; aPos = 1'b0;
    #2 reset = 1'b0;
    repeat (3) begin tick(); expect_v(V_START, "reset"); end
    reset = 1'b1;

    instr(3'b000, 0, 0, V_LOAD,  "load");
    instr(3'b001, 0, 0, V_STORE, "store");
    instr(3'b010, 0, 0, V_ADD,   "add");
    instr(3'b011, 0, 0, V_SUB,   "sub");
    instr(3'b101, 1, 0, V_JZ_T,  "jz_taken");
    instr(3'b101, 0, 1, V_JZ_N,  "jz_not");
    instr(3'b110, 0, 1, V_JP_T,  "jpos_taken");
    instr(3'b110, 1, 0, V_JP_N,  "jpos_not");

    // IN: wait without enter, then one pulse SYNC+1 edges after the rise.
    fetch_decode(3'b100, "in1");
    repeat (10) begin tick(); expect_v(V_INWAIT, "in1_wait"); end
    enter = 1'b1;
    repeat (SYNC) begin tick(); expect_v(V_INWAIT, "in1_sync"); end
    tick(); expect_v(V_INGO, "in1_go");
    // Second IN with enter still held must not complete.
    fetch_decode(3'b100, "in2");
    repeat (15) begin tick(); expect_v(V_INWAIT, "in2_held"); end
    enter = 1'b0;
    repeat (4) begin tick(); expect_v(V_INWAIT, "in2_low"); end
    enter = 1'b1;
    repeat (SYNC) begin tick(); expect_v(V_INWAIT, "in2_sync"); end
    tick(); expect_v(V_INGO, "in2_go");
    enter = 1'b0;
    instr(3'b010, 0, 0, V_ADD, "add_after_in");

    // Reset during STORE, then restart from START.
    fetch_decode(3'b001, "store_rst");
    tick(); expect_v(V_STORE, "store_rst_exec");
    async_reset("store_rst_async");
    instr(3'b000, 0, 0, V_LOAD, "load_after_rst");

    // HALT is terminal; enter toggles are ignored.
    fetch_decode(3'b111, "halt");
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i % 5 == 0) enter = ~enter;
      expect_v(V_HALT, "halt_hold");
    end
    enter = 1'b0;
    async_reset("halt_rst_async");
    instr(3'b011, 0, 0, V_SUB, "sub_after_halt");

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Finite-state controller for the 8-bit accumulator processor. It consumes the status signals from the processor datapath: the 3-bit opcode, the accumulator-zero flag and the accumulator-positive flag.
- It drives every datapath control strobe: IR load, PC load, jump mux, memory-address select, memory write, A-register source select, A load and the add/subtract select.
- It also owns the operator "enter" handshake for the IN instruction and the halt indication.
- The processor top instantiates it beside the datapath, one per processor.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the enter-button synchronizer (minimum 2).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ir  input  3  opcode, ir[2:0] = instruction bits [7:5].
- aEq0  input  1  accumulator == 0.
- aPos  input  1  accumulator bit 7 == 0.
- enter  input  1  asynchronous operator button; a rising edge confirms IN data.
- irLoad  output  1  load IR from memory.
- pcLoad  output  1  load PC.
- jmpMux  output  1  PC source: 1 = IR[4:0], 0 = PC+1.
- memInst  output  1  memory address: 1 = IR[4:0], 0 = PC.
- memWr  output  1  write A to memory.
- aSel  output  2  A source: 00 = add/sub result, 01 = dataIn, 10 = RAM, 11 = unused (never driven).
- aLoad  output  1  load A.
- sub  output  1  1 = subtract, 0 = add.
- halt  output  1  high while in HALT.
- state  output  4  current state encoding, for debug.

Behaviour:
- Moore machine. All outputs decode from the state register only, except pcLoad in JZ/JPOS and aLoad in INPUT (see those states).
- Reset (reset = 0, asynchronous):
  - state = START.
  - All strobes 0, aSel = 00, halt = 0.
  - Synchronizer and edge-detect flops cleared.
  - Reset asserted mid-instruction aborts it immediately; no partial write completes after reset asserts.
- States and outputs (any strobe not listed is 0):
  - START: all strobes 0; next state FETCH. Gives one idle cycle after reset release.
  - FETCH: irLoad = 1, pcLoad = 1, jmpMux = 0, memInst = 0. IR <= mem[PC], PC <= PC+1. Next state DECODE.
  - DECODE: memInst = 1. The operand address settles. Next state by opcode: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
  - LOAD: memInst = 1, aSel = 10, aLoad = 1. Next state FETCH.
  - STORE: memInst = 1, memWr = 1. Next state FETCH.
  - ADD: memInst = 1, aSel = 00, sub = 0, aLoad = 1. Next state FETCH.
  - SUB: memInst = 1, aSel = 00, sub = 1, aLoad = 1. Next state FETCH.
  - INPUT: aSel = 01; aLoad = enterPulse.
    - Stay in INPUT while enterPulse = 0; go to FETCH on the cycle enterPulse = 1.
  - JZ: jmpMux = 1, pcLoad = aEq0. Next state FETCH.
  - JPOS: jmpMux = 1, pcLoad = aPos. Next state FETCH.
  - HALT: halt = 1, all strobes 0. Self-loop; only reset exits.
- Latency per instruction (cycles, counting FETCH, DECODE and execute):
  - LOAD, STORE, ADD, SUB, JZ, JPOS: 3 cycles.
  - INPUT: 3 cycles plus the wait for enter.
  - HALT: terminal.
- Enter handshake:
  - enter passes through a SYNC_STAGES flip-flop synchronizer, then a rising-edge detector.
  - enterPulse is a 1-cycle pulse, regardless of how long enter is held.
  - enterPulse is consumed only in INPUT; pulses in any other state are discarded, not queued.
  - Holding enter high across two IN instructions completes only the first; the second waits for a new rising edge.
- Flags are sampled combinationally in JZ/JPOS. aEq0/aPos reflect A as updated by the previous instruction.
- Illegal state encodings recover to START on the next clock.
- memWr and aLoad are never asserted in the same cycle. aSel = 11 never occurs.

Decomposition:
- Shared package control_pkg holds:
  - state encodings (4-bit): START = 0, FETCH = 1, DECODE = 2, LOAD = 3, STORE = 4, ADD = 5, SUB = 6, INPUT = 7, JZ = 8, JPOS = 9, HALT = 10.
  - opcode constants OP_LOAD = 000 through OP_HALT = 111.
  - aSel constants ASEL_ALU = 00, ASEL_IN = 01, ASEL_RAM = 10.
- One sub-module: enter_sync, the parameterized synchronizer plus rising-edge pulse generator, with clock and the same active-low reset.

Test Plan:
- Reset held low, then released → state = START for 1 cycle, then FETCH with irLoad = pcLoad = 1; all other strobes 0 throughout reset.
- ir = 000 at DECODE → LOAD asserts memInst = 1, aSel = 10, aLoad = 1 for exactly 1 cycle, then FETCH; same check for 010 (sub = 0), 011 (sub = 1) and 001 (memWr = 1, aLoad = 0).
- ir = 101 with aEq0 = 1 → JZ cycle shows jmpMux = 1, pcLoad = 1; repeat with aEq0 = 0 → pcLoad = 0. Check ir = 110 against aPos the same way.
- ir = 100, enter low for 10 cycles → state stays INPUT, aLoad = 0. Raise enter and hold it for 20 cycles → aLoad = 1 exactly once, SYNC_STAGES+1 cycles after the edge, then FETCH. A following IN waits for a fresh edge.
- ir = 111 → halt = 1 and the state stays HALT for 50 cycles with no strobes; toggling enter has no effect. Reset low mid-HALT → halt = 0 asynchronously.
- Reset asserted during the STORE cycle → memWr drops to 0 before the next clock edge; after release the sequence restarts at START.
